id_ex_stage: RTL and testbench

ID_EX_STAGE -- requirements
Module: id_ex_stage

---
 rtl/id_ex_stage.sv | 163 ++++++++++++++++
 tb/tb_id_ex_stage.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// id_ex_stage: one-entry ID/EX pipeline register slice with load-use hazard
// detection, bubble insertion and branch flush.
// Optional feature: define FORWARD_EN to add the Ex_* ports and let a result
// leaving execute replace stale register-file operands at capture time.
module id_ex_stage (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        In_Valid,
  output logic        In_Ready,
  input  logic [31:0] Rs_Data,
  input  logic [31:0] Rt_Data,
  input  logic [31:0] Imm,
  input  logic [4:0]  Rs,
  input  logic [4:0]  Rt,
  input  logic [4:0]  Rd,
  input  logic        ALUSrc,
  input  logic        RegWrite,
  input  logic        MemRead,
  input  logic        Flush,
`ifdef FORWARD_EN
  input  logic [31:0] Ex_Result,
  input  logic [4:0]  Ex_Rd,
  input  logic        Ex_RegWrite,
`endif
  output logic        Out_Valid,
  input  logic        Out_Ready,
  output logic [31:0] Out_A,
  output logic [31:0] Out_B,
  output logic [31:0] Out_Imm,
  output logic        Out_ALUSrc,
  output logic [4:0]  Out_Rd,
  output logic        Out_RegWrite,
  output logic        Out_MemRead,
  output logic        Hazard
);

  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    FULL   = 2'd1,
    BUBBLE = 2'd2
  } state_t;

  state_t      state_r;
  logic        out_valid_r;
  logic [31:0] a_r;
  logic [31:0] b_r;
  logic [31:0] imm_r;
  logic [4:0]  rd_r;
  logic        alusrc_r;
  logic        regwrite_r;
  logic        memread_r;

  logic        hazard_s;
  logic        in_ready_s;
  logic        transfer_s;
  logic [31:0] rs_val_s;
  logic [31:0] rt_val_s;

  // Load-use detection: the held load's destination is a source of the offered
  // instruction; register 0 is hard-wired and never creates a dependency.
  always_comb begin
    hazard_s = 1'b0;
    if ((state_r == FULL) && memread_r && (rd_r != 5'd0) && In_Valid &&
        ((Rs == rd_r) || (Rt == rd_r))) begin
      hazard_s = 1'b1;
    end else begin
      hazard_s = 1'b0;
    end
  end

  // Handshake: accept when the slot frees this cycle, unless stalling or flushing.
  always_comb begin
    in_ready_s = (~out_valid_r | Out_Ready) & ~hazard_s & ~Flush;
    transfer_s = In_Valid & in_ready_s;
  end

  // Operand selection at capture; execute-stage results override each source independently.
  always_comb begin
    rs_val_s = Rs_Data;
    rt_val_s = Rt_Data;
`ifdef FORWARD_EN
    if (Ex_RegWrite && (Ex_Rd != 5'd0) && (Ex_Rd == Rs)) begin
      rs_val_s = Ex_Result;
    end else begin
      rs_val_s = Rs_Data;
    end
    if (Ex_RegWrite && (Ex_Rd != 5'd0) && (Ex_Rd == Rt)) begin
      rt_val_s = Ex_Result;
    end else begin
      rt_val_s = Rt_Data;
    end
`endif
  end

  // Slice state machine: flush dominates, then capture, then drain/bubble/hold.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_r     <= EMPTY;
      out_valid_r <= 1'b0;
      a_r         <= 32'h0;
      b_r         <= 32'h0;
      imm_r       <= 32'h0;
      rd_r        <= 5'd0;
      alusrc_r    <= 1'b0;
      regwrite_r  <= 1'b0;
      memread_r   <= 1'b0;
    end else if (Flush) begin
      state_r     <= EMPTY;
      out_valid_r <= 1'b0;
      regwrite_r  <= 1'b0;
      memread_r   <= 1'b0;
    end else if (transfer_s) begin
      state_r     <= FULL;
      out_valid_r <= 1'b1;
      a_r         <= rs_val_s;
      b_r         <= rt_val_s;
      imm_r       <= Imm;
      rd_r        <= Rd;
      alusrc_r    <= ALUSrc;
      regwrite_r  <= RegWrite;
      memread_r   <= MemRead;
    end else begin
      case (state_r)
        EMPTY, BUBBLE: begin
          state_r     <= EMPTY;
          out_valid_r <= 1'b0;
          regwrite_r  <= 1'b0;
          memread_r   <= 1'b0;
        end
        FULL: begin
          if (Out_Ready) begin
            // A stalled dependent leaves one cycle of no-op behind the load.
            state_r     <= hazard_s ? BUBBLE : EMPTY;
            out_valid_r <= 1'b0;
            regwrite_r  <= 1'b0;
            memread_r   <= 1'b0;
          end else begin
            state_r     <= FULL;
            out_valid_r <= 1'b1;
          end
        end
        default: begin
          state_r     <= EMPTY;
          out_valid_r <= 1'b0;
          regwrite_r  <= 1'b0;
          memread_r   <= 1'b0;
        end
      endcase
    end
  end

  assign In_Ready     = in_ready_s;
  assign Hazard       = hazard_s;
  assign Out_Valid    = out_valid_r;
  assign Out_A        = a_r;
  assign Out_B        = b_r;
  assign Out_Imm      = imm_r;
  assign Out_ALUSrc   = alusrc_r;
  assign Out_Rd       = rd_r;
  assign Out_RegWrite = regwrite_r;
  assign Out_MemRead  = memread_r;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed vectors with a scoreboard queue; a monitor pops and
// compares every instruction consumed from the execute slot.
module tb_id_ex_stage;

  logic        Clk;
  logic        Reset_n;
  logic        In_Valid;
  logic        In_Ready;
  logic [31:0] Rs_Data;
  logic [31:0] Rt_Data;
  logic [31:0] Imm;
  logic [4:0]  Rs;
  logic [4:0]  Rt;
  logic [4:0]  Rd;
  logic        ALUSrc;
  logic        RegWrite;
  logic        MemRead;
  logic        Flush;
`ifdef FORWARD_EN
  logic [31:0] Ex_Result;
  logic [4:0]  Ex_Rd;
  logic        Ex_RegWrite;
`endif
  logic        Out_Valid;
  logic        Out_Ready;
  logic [31:0] Out_A;
  logic [31:0] Out_B;
  logic [31:0] Out_Imm;
  logic        Out_ALUSrc;
  logic [4:0]  Out_Rd;
  logic        Out_RegWrite;
  logic        Out_MemRead;
  logic        Hazard;

  typedef struct packed {
    logic        v;
    logic [31:0] rsd;
    logic [31:0] rtd;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic        als;
    logic        rw;
    logic        mr;
  } ins_t;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic        als;
    logic        rw;
    logic        mr;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  id_ex_stage dut (
    .Clk(Clk), .Reset_n(Reset_n), .In_Valid(In_Valid), .In_Ready(In_Ready),
    .Rs_Data(Rs_Data), .Rt_Data(Rt_Data), .Imm(Imm), .Rs(Rs), .Rt(Rt), .Rd(Rd),
    .ALUSrc(ALUSrc), .RegWrite(RegWrite), .MemRead(MemRead), .Flush(Flush),
`ifdef FORWARD_EN
    .Ex_Result(Ex_Result), .Ex_Rd(Ex_Rd), .Ex_RegWrite(Ex_RegWrite),
`endif
    .Out_Valid(Out_Valid), .Out_Ready(Out_Ready), .Out_A(Out_A), .Out_B(Out_B),
    .Out_Imm(Out_Imm), .Out_ALUSrc(Out_ALUSrc), .Out_Rd(Out_Rd),
    .Out_RegWrite(Out_RegWrite), .Out_MemRead(Out_MemRead), .Hazard(Hazard)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic ins_t mk(input logic v, input logic [31:0] rsd, input logic [31:0] rtd,
                              input logic [31:0] imm, input logic [4:0] rs, input logic [4:0] rt,
                              input logic [4:0] rd, input logic als, input logic rw, input logic mr);
    ins_t i;
    i.v = v; i.rsd = rsd; i.rtd = rtd; i.imm = imm; i.rs = rs; i.rt = rt; i.rd = rd;
    i.als = als; i.rw = rw; i.mr = mr;
    return i;
  endfunction

  function automatic exp_t ex(input ins_t i);
    exp_t e;
    e.a = i.rsd; e.b = i.rtd; e.imm = i.imm; e.rd = i.rd;
    e.als = i.als; e.rw = i.rw; e.mr = i.mr;
    return e;
  endfunction

  // Drive one cycle of stimulus, check the handshake, record what must emerge.
  task automatic step(input ins_t i, input exp_t e, input logic ordy, input logic fl,
                      input logic exp_rdy, input logic exp_haz);
    @(posedge Clk);
    #1;
    In_Valid = i.v; Rs_Data = i.rsd; Rt_Data = i.rtd; Imm = i.imm;
    Rs = i.rs; Rt = i.rt; Rd = i.rd; ALUSrc = i.als; RegWrite = i.rw; MemRead = i.mr;
    Out_Ready = ordy; Flush = fl;
    @(negedge Clk);
    check("in_ready", 32'(In_Ready), 32'(exp_rdy));
    check("hazard", 32'(Hazard), 32'(exp_haz));
    if (exp_rdy && i.v) q.push_back(e);
  endtask

  task automatic check_zero(input string nm);
    check({nm, "_ctl"}, 32'({Out_Valid, Out_ALUSrc, Out_RegWrite, Out_MemRead, Hazard}), 32'h0);
    check({nm, "_a"}, Out_A, 32'h0);
    check({nm, "_b"}, Out_B, 32'h0);
    check({nm, "_imm"}, Out_Imm, 32'h0);
    check({nm, "_rd"}, 32'(Out_Rd), 32'h0);
  endtask

  // Monitor: every consumed instruction must match the oldest expected entry.
  initial begin
    exp_t e;
    forever begin
      @(negedge Clk);
      if (Reset_n && Out_Valid && Out_Ready) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out: got A=%h Rd=%0d expected nothing at %0t", Out_A, Out_Rd, $time);
        end else begin
          e = q.pop_front();
          check("out_a", Out_A, e.a);
          check("out_b", Out_B, e.b);
          check("out_imm", Out_Imm, e.imm);
          check("out_ctl", 32'({Out_Rd, Out_ALUSrc, Out_RegWrite, Out_MemRead}),
                32'({e.rd, e.als, e.rw, e.mr}));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    ins_t idle, i1, i2, i3, lw, add, lw2, add2, lw3, add3, i4, i5, i6, i7, i8;
    exp_t e;
    idle = mk(1'b0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    i1   = mk(1'b1, 32'h11, 32'h22, 32'h33, 5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 1'b0);
    i2   = mk(1'b1, 32'hA0A0_0001, 32'hB0B0_0002, 32'hFFFF_FFFC, 5'd10, 5'd11, 5'd12, 1'b1, 1'b1, 1'b0);
    i3   = mk(1'b1, 32'h0000_1234, 32'h0000_5678, 32'h0000_0010, 5'd13, 5'd14, 5'd15, 1'b0, 1'b0, 1'b0);
    lw   = mk(1'b1, 32'h0000_0100, 32'h0, 32'h0000_0008, 5'd6, 5'd7, 5'd5, 1'b1, 1'b1, 1'b1);
    add  = mk(1'b1, 32'h0000_0055, 32'h0000_0066, 32'h0, 5'd5, 5'd8, 5'd9, 1'b0, 1'b1, 1'b0);
    lw2  = mk(1'b1, 32'h0000_0200, 32'h0, 32'h0000_0004, 5'd2, 5'd0, 5'd4, 1'b1, 1'b1, 1'b1);
    add2 = mk(1'b1, 32'h0000_0077, 32'h0000_0088, 32'h0, 5'd1, 5'd4, 5'd6, 1'b0, 1'b1, 1'b0);
    lw3  = mk(1'b1, 32'h0000_0300, 32'h0, 32'h0, 5'd3, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1);
    add3 = mk(1'b1, 32'h0000_0099, 32'h0000_00AA, 32'h0, 5'd0, 5'd0, 5'd7, 1'b0, 1'b1, 1'b0);
    i4   = mk(1'b1, 32'hCAFE_0004, 32'h4, 32'h4, 5'd1, 5'd2, 5'd20, 1'b0, 1'b1, 1'b0);
    i5   = mk(1'b1, 32'hCAFE_0005, 32'h5, 32'h5, 5'd1, 5'd2, 5'd21, 1'b0, 1'b1, 1'b0);
    i6   = mk(1'b1, 32'hBEEF_0006, 32'h6, 32'h6, 5'd1, 5'd2, 5'd22, 1'b1, 1'b1, 1'b1);
    i7   = mk(1'b1, 32'hBEEF_0007, 32'h7, 32'h7, 5'd1, 5'd2, 5'd23, 1'b0, 1'b1, 1'b0);
    i8   = mk(1'b1, 32'h0000_0008, 32'h8, 32'h8, 5'd1, 5'd2, 5'd24, 1'b0, 1'b1, 1'b0);

    Reset_n = 1'b0; In_Valid = 1'b0; Rs_Data = 32'h0; Rt_Data = 32'h0; Imm = 32'h0;
    Rs = 5'd0; Rt = 5'd0; Rd = 5'd0; ALUSrc = 1'b0; RegWrite = 1'b0; MemRead = 1'b0;
    Flush = 1'b0; Out_Ready = 1'b0;
`ifdef FORWARD_EN
    Ex_Result = 32'h0; Ex_Rd = 5'd0; Ex_RegWrite = 1'b0;
`endif
    repeat (2) @(negedge Clk);
    check_zero("reset");
    @(posedge Clk); #1; Reset_n = 1'b1;

    // Basic transfer and one-cycle latency
    step(i1, ex(i1), 1'b1, 1'b0, 1'b1, 1'b0);
    step(idle, ex(idle), 1'b1, 1'b0, 1'b1, 1'b0);

    // Back-pressure: hold three cycles, then capture the next one on release
    step(i2, ex(i2), 1'b0, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step(i3, ex(i3), 1'b0, 1'b0, 1'b0, 1'b0);
      check("hold_valid", 32'(Out_Valid), 32'h1);
      check("hold_a", Out_A, 32'hA0A0_0001);
      check("hold_imm", Out_Imm, 32'hFFFF_FFFC);
    end
    step(i3, ex(i3), 1'b1, 1'b0, 1'b1, 1'b0);
    step(idle, ex(idle), 1'b1, 1'b0, 1'b1, 1'b0);

    // Load-use with execute ready: one bubble, dependent follows
    step(lw, ex(lw), 1'b1, 1'b0, 1'b1, 1'b0);
    step(add, ex(add), 1'b1, 1'b0, 1'b0, 1'b1);
    step(add, ex(add), 1'b1, 1'b0, 1'b1, 1'b0);
    check("bubble_ctl", 32'({Out_Valid, Out_RegWrite, Out_MemRead}), 32'h0);
    step(idle, ex(idle), 1'b1, 1'b0, 1'b1, 1'b0);

    // Load-use with execute stalled: load held, hazard persists
    step(lw2, ex(lw2), 1'b1, 1'b0, 1'b1, 1'b0);
    step(add2, ex(add2), 1'b0, 1'b0, 1'b0, 1'b1);
    step(add2, ex(add2), 1'b0, 1'b0, 1'b0, 1'b1);
    check("haz_hold_a", Out_A, 32'h0000_0200);
    check("haz_hold_mr", 32'({Out_Valid, Out_MemRead}), 32'h3);
    step(add2, ex(add2), 1'b1, 1'b0, 1'b0, 1'b1);
    step(add2, ex(add2), 1'b1, 1'b0, 1'b1, 1'b0);
    step(idle, ex(idle), 1'b1, 1'b0, 1'b1, 1'b0);

    // Load to register 0 never stalls
    step(lw3, ex(lw3), 1'b1, 1'b0, 1'b1, 1'b0);
    step(add3, ex(add3), 1'b1, 1'b0, 1'b1, 1'b0);
    step(idle, ex(idle), 1'b1, 1'b0, 1'b1, 1'b0);

    // Flush kills the held and the offered instruction
    step(i4, ex(i4), 1'b1, 1'b0, 1'b1, 1'b0);
    step(i5, ex(i5), 1'b0, 1'b1, 1'b0, 1'b0);
    void'(q.pop_back());
    step(idle, ex(idle), 1'b1, 1'b0, 1'b1, 1'b0);
    check("flush_ctl", 32'({Out_Valid, Out_RegWrite, Out_MemRead}), 32'h0);
    step(idle, ex(idle), 1'b1, 1'b0, 1'b1, 1'b0);

`ifdef FORWARD_EN
    // Forwarding: both sources, one source, and register 0 ignored
    Ex_RegWrite = 1'b1; Ex_Rd = 5'd3; Ex_Result = 32'hDEAD;
    e = ex(mk(1'b1, 32'h1, 32'h2, 32'h0, 5'd3, 5'd3, 5'd8, 1'b0, 1'b1, 1'b0));
    e.a = 32'hDEAD; e.b = 32'hDEAD;
    step(mk(1'b1, 32'h1, 32'h2, 32'h0, 5'd3, 5'd3, 5'd8, 1'b0, 1'b1, 1'b0), e, 1'b1, 1'b0, 1'b1, 1'b0);
    e = ex(mk(1'b1, 32'h3, 32'h4, 32'h0, 5'd3, 5'd4, 5'd9, 1'b0, 1'b1, 1'b0));
    e.a = 32'hDEAD;
    step(mk(1'b1, 32'h3, 32'h4, 32'h0, 5'd3, 5'd4, 5'd9, 1'b0, 1'b1, 1'b0), e, 1'b1, 1'b0, 1'b1, 1'b0);
    Ex_Rd = 5'd0;
    e = ex(mk(1'b1, 32'h5, 32'h6, 32'h0, 5'd0, 5'd0, 5'd10, 1'b0, 1'b1, 1'b0));
    step(mk(1'b1, 32'h5, 32'h6, 32'h0, 5'd0, 5'd0, 5'd10, 1'b0, 1'b1, 1'b0), e, 1'b1, 1'b0, 1'b1, 1'b0);
    Ex_RegWrite = 1'b0;
    step(idle, ex(idle), 1'b1, 1'b0, 1'b1, 1'b0);
`endif

    // Reset pulsed mid-stream: outputs clear at once, nothing stale afterwards
    step(i6, ex(i6), 1'b0, 1'b0, 1'b1, 1'b0);
    @(posedge Clk); #1;
    In_Valid = i7.v; Rs_Data = i7.rsd; Rd = i7.rd;
    Reset_n = 1'b0;
    #1;
    check_zero("midreset");
    q.delete();
    @(posedge Clk); #1;
    In_Valid = 1'b0; Reset_n = 1'b1;
    step(idle, ex(idle), 1'b1, 1'b0, 1'b1, 1'b0);
    check("post_reset_valid", 32'(Out_Valid), 32'h0);
    step(i8, ex(i8), 1'b1, 1'b0, 1'b1, 1'b0);
    step(idle, ex(idle), 1'b1, 1'b0, 1'b1, 1'b0);
    step(idle, ex(idle), 1'b1, 1'b0, 1'b1, 1'b0);

    check("queue_drained", 32'(q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
